// File: rtl/de_stage.sv
// rtl/de_stage.sv - LC-3b decode stage: control-store addressing, scoreboard hazard check, AGEX latch (optional DE_PERF_CNT_EN counters)
module de_stage #(
  parameter int CS_WIDTH      = 23,
  parameter int CS_LD_REG_BIT = 22,
  parameter int SB_MAX        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                de_valid_in,
  input  logic [15:0]         de_ir,
  input  logic [15:0]         de_npc,
  output logic [5:0]          cs_addr,
  input  logic [CS_WIDTH-1:0] cs_bits,
  input  logic                agex_stall,
  input  logic                flush,
  input  logic                sb_dec_valid,
  input  logic [2:0]          sb_dec_dr,
  output logic                de_stall,
  output logic                agex_valid,
  output logic [15:0]         agex_ir,
  output logic [15:0]         agex_npc,
  output logic [CS_WIDTH-1:0] agex_cs,
`ifdef DE_PERF_CNT_EN
  output logic [15:0]         perf_stall_cnt,
  output logic [15:0]         perf_bubble_cnt,
`endif
  output logic [2:0]          agex_dr
);

  localparam logic [1:0] SB_FULL = 2'(SB_MAX);

  logic [3:0] opcode;
  logic [2:0] dr;
  logic       writes_dr;
  logic       sr1_busy, sr2_busy, sr3_busy, dr_full;
  logic       hazard, issue;
  logic [1:0] sb_cnt [8];
  logic [7:0] sb_inc, sb_dec;

  assign opcode    = de_ir[15:12];
  assign cs_addr   = {de_ir[15:12], de_ir[11], de_ir[5]};
  assign dr        = (opcode == 4'b0100) ? 3'd7 : de_ir[11:9];
  assign writes_dr = cs_bits[CS_LD_REG_BIT];

  // Source checks are conservative: any field that might be a source is treated as one.
  assign sr1_busy = (sb_cnt[de_ir[8:6]] != 2'd0);
  assign sr2_busy = ~de_ir[5] & (sb_cnt[de_ir[2:0]] != 2'd0);
  assign sr3_busy = ((opcode == 4'b0011) | (opcode == 4'b0111)) & (sb_cnt[de_ir[11:9]] != 2'd0);
  assign dr_full  = writes_dr & (sb_cnt[dr] == SB_FULL);

  assign hazard   = de_valid_in & (sr1_busy | sr2_busy | sr3_busy | dr_full);
  assign de_stall = de_valid_in & (hazard | agex_stall) & ~flush;
  assign issue    = de_valid_in & ~hazard & ~agex_stall & ~flush;

  // Per-register increment/decrement requests for this cycle.
  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    for (int i = 0; i < 8; i++) begin
      sb_inc[i] = issue & writes_dr & (dr == 3'(i));
      sb_dec[i] = sb_dec_valid & (sb_dec_dr == 3'(i));
    end
  end

  // Pending-write scoreboard; simultaneous inc/dec on one register cancels, dec at zero holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) sb_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sb_inc[i] && !sb_dec[i])
          sb_cnt[i] <= sb_cnt[i] + 2'd1;
        else if (sb_dec[i] && !sb_inc[i] && sb_cnt[i] != 2'd0)
          sb_cnt[i] <= sb_cnt[i] - 2'd1;
      end
    end
  end

  // AGEX latch: flush beats stall, stall holds, otherwise issue or insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agex_valid <= 1'b0;
      agex_ir    <= '0;
      agex_npc   <= '0;
      agex_cs    <= '0;
      agex_dr    <= '0;
    end else if (flush) begin
      agex_valid <= 1'b0;
    end else if (agex_stall) begin
      agex_valid <= agex_valid;
    end else if (issue) begin
      agex_valid <= 1'b1;
      agex_ir    <= de_ir;
      agex_npc   <= de_npc;
      agex_cs    <= cs_bits;
      agex_dr    <= dr;
    end else begin
      agex_valid <= 1'b0;
    end
  end

`ifdef DE_PERF_CNT_EN
  logic hazard_bubble;
  assign hazard_bubble = de_valid_in & hazard & ~agex_stall & ~flush;

  // Saturating stall and hazard-bubble event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (de_stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (hazard_bubble && perf_bubble_cnt != 16'hFFFF)
        perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_de_stage.sv
// tb/tb_de_stage.sv - self-checking bench for de_stage (directed table, random vs model, reset/perf sequences)
module tb_de_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_valid_in = 1'b0;
  logic [15:0] de_ir = '0;
  logic [15:0] de_npc = '0;
  logic [5:0]  cs_addr;
  logic [22:0] cs_bits = '0;
  logic        agex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        sb_dec_valid = 1'b0;
  logic [2:0]  sb_dec_dr = '0;
  logic        de_stall;
  logic        agex_valid;
  logic [15:0] agex_ir;
  logic [15:0] agex_npc;
  logic [22:0] agex_cs;
  logic [2:0]  agex_dr;
`ifdef DE_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  de_stage dut (
    .clk(clk), .rst(rst), .de_valid_in(de_valid_in), .de_ir(de_ir), .de_npc(de_npc),
    .cs_addr(cs_addr), .cs_bits(cs_bits), .agex_stall(agex_stall), .flush(flush),
    .sb_dec_valid(sb_dec_valid), .sb_dec_dr(sb_dec_dr), .de_stall(de_stall),
    .agex_valid(agex_valid), .agex_ir(agex_ir), .agex_npc(agex_npc), .agex_cs(agex_cs),
`ifdef DE_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .agex_dr(agex_dr)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          sb [8];
  logic        m_valid;
  logic [15:0] m_ir, m_npc;
  logic [22:0] m_cs;
  logic [2:0]  m_dr;
  int          m_pstall, m_pbub;

  logic        obs_stall;
  logic [5:0]  obs_addr;

  typedef struct {
    logic v; logic [15:0] ir; logic ld; logic as; logic fl; logic dv; logic [2:0] ddr;
    logic [5:0] e_addr; logic e_stall; logic e_av; logic chk_dr; logic [2:0] e_dr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset;
    for (int k = 0; k < 8; k++) sb[k] = 0;
    m_valid = 1'b0; m_ir = '0; m_npc = '0; m_cs = '0; m_dr = '0;
    m_pstall = 0; m_pbub = 0;
  endtask

  task automatic add(input logic v, input logic [15:0] ir, input logic ld, input logic as,
                     input logic fl, input logic dv, input logic [2:0] ddr, input logic [5:0] ea,
                     input logic es, input logic eav, input logic cdr, input logic [2:0] edr);
    tbl.push_back('{v, ir, ld, as, fl, dv, ddr, ea, es, eav, cdr, edr});
  endtask

  // One clock of stimulus, checked against the model before and after the edge.
  task automatic step(input logic v, input logic [15:0] ir, input logic [15:0] npc,
                      input logic [22:0] cs, input logic as, input logic fl,
                      input logic dv, input logic [2:0] ddr);
    int opc, dr, dd;
    int srcs[$];
    bit haz, stl, iss, wr;
    @(negedge clk);
    de_valid_in = v; de_ir = ir; de_npc = npc; cs_bits = cs;
    agex_stall = as; flush = fl; sb_dec_valid = dv; sb_dec_dr = ddr;
    opc = 32'(ir[15:12]);
    dr  = (opc == 4) ? 7 : 32'(ir[11:9]);
    dd  = 32'(ddr);
    wr  = cs[22];
    srcs.push_back(32'(ir[8:6]));
    if (!ir[5]) srcs.push_back(32'(ir[2:0]));
    if (opc == 3 || opc == 7) srcs.push_back(32'(ir[11:9]));
    haz = 1'b0;
    foreach (srcs[k]) if (sb[srcs[k]] != 0) haz = 1'b1;
    if (wr && sb[dr] >= 3) haz = 1'b1;
    haz = haz && v;
    stl = v && (haz || as) && !fl;
    iss = v && !haz && !as && !fl;
    #1;
    obs_stall = de_stall;
    obs_addr  = cs_addr;
    chk("cs_addr", 32'(cs_addr), {26'd0, ir[15:12], ir[11], ir[5]});
    chk("de_stall", 32'(de_stall), 32'(stl));
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (as) m_valid = m_valid;
    else if (iss) begin
      m_valid = 1'b1; m_ir = ir; m_npc = npc; m_cs = cs; m_dr = 3'(dr);
    end else m_valid = 1'b0;
    if (iss && wr && dv && dd == dr) begin
      // same register written and released: net zero
    end else begin
      if (iss && wr) sb[dr] = sb[dr] + 1;
      if (dv && sb[dd] > 0) sb[dd] = sb[dd] - 1;
    end
    if (stl && m_pstall < 65535) m_pstall++;
    if (v && haz && !as && !fl && m_pbub < 65535) m_pbub++;
    #1;
    chk("agex_valid", 32'(agex_valid), 32'(m_valid));
    if (m_valid) begin
      chk("agex_ir", 32'(agex_ir), 32'(m_ir));
      chk("agex_npc", 32'(agex_npc), 32'(m_npc));
      chk("agex_cs", 32'(agex_cs), 32'(m_cs));
      chk("agex_dr", 32'(agex_dr), 32'(m_dr));
    end
`ifdef DE_PERF_CNT_EN
    chk("perf_stall", 32'(perf_stall_cnt), 32'(m_pstall));
    chk("perf_bubble", 32'(perf_bubble_cnt), 32'(m_pbub));
`endif
  endtask

  // Raise rst with the current inputs still applied; everything must clear at once.
  task automatic reset_check;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_de_stall", 32'(de_stall), 32'd0);
    chk("rst_agex_valid", 32'(agex_valid), 32'd0);
    chk("rst_agex_ir", 32'(agex_ir), 32'd0);
    chk("rst_agex_npc", 32'(agex_npc), 32'd0);
    chk("rst_agex_cs", 32'(agex_cs), 32'd0);
    chk("rst_agex_dr", 32'(agex_dr), 32'd0);
`ifdef DE_PERF_CNT_EN
    chk("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
    chk("rst_perf_bubble", 32'(perf_bubble_cnt), 32'd0);
`endif
    model_reset;
    de_valid_in = 1'b0; agex_stall = 1'b0; flush = 1'b0; sb_dec_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //   v  ir        ld as fl dv ddr  addr  stl av cdr dr
    add(1, 16'h1283, 1, 0, 0, 0, 0, 6'd4,  0, 1, 1, 1);  // ADD R1,R2,R3
    add(1, 16'h1861, 1, 0, 0, 0, 0, 6'd7,  1, 0, 0, 0);  // ADD R4,R1,#1 waits on R1
    add(1, 16'h1861, 1, 0, 0, 0, 0, 6'd7,  1, 0, 0, 0);
    add(1, 16'h1861, 1, 0, 0, 1, 1, 6'd7,  1, 0, 0, 0);  // release R1
    add(1, 16'h1861, 1, 0, 0, 0, 0, 6'd7,  0, 1, 1, 4);
    add(1, 16'h5A3F, 0, 1, 0, 0, 0, 6'd23, 1, 1, 1, 4);  // agex_stall holds latch
    add(1, 16'h5A3F, 0, 1, 0, 0, 0, 6'd23, 1, 1, 1, 4);
    add(1, 16'h5A3F, 0, 1, 0, 0, 0, 6'd23, 1, 1, 1, 4);
    add(1, 16'h5A3F, 0, 0, 0, 0, 0, 6'd23, 0, 1, 1, 5);
    add(1, 16'h1600, 1, 1, 1, 0, 0, 6'd4,  0, 0, 0, 0);  // flush+stall, R3 writer squashed
    add(1, 16'h10C0, 0, 0, 0, 0, 0, 6'd4,  0, 1, 1, 0);  // reads R3: must not stall
    add(0, 16'h0000, 0, 0, 0, 1, 4, 6'd0,  0, 0, 0, 0);  // release R4
    add(1, 16'h1A00, 1, 0, 0, 0, 0, 6'd6,  0, 1, 1, 5);  // three R5 writers
    add(1, 16'h1A00, 1, 0, 0, 0, 0, 6'd6,  0, 1, 1, 5);
    add(1, 16'h1A00, 1, 0, 0, 0, 0, 6'd6,  0, 1, 1, 5);
    add(1, 16'h1A00, 1, 0, 0, 0, 0, 6'd6,  1, 0, 0, 0);  // fourth stalls at SB_MAX
    add(0, 16'h0000, 0, 0, 0, 1, 5, 6'd0,  0, 0, 0, 0);  // R5 -> 2
    add(1, 16'h1A00, 1, 0, 0, 1, 5, 6'd6,  0, 1, 1, 5);  // issue+release R5: stays 2
    add(1, 16'h1A00, 1, 0, 0, 0, 0, 6'd6,  0, 1, 1, 5);  // R5 -> 3
    add(1, 16'h1A00, 1, 0, 0, 0, 0, 6'd6,  1, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 5, 6'd0,  0, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 5, 6'd0,  0, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 5, 6'd0,  0, 0, 0, 0);
    add(1, 16'h4800, 1, 0, 0, 0, 0, 6'd18, 0, 1, 1, 7);  // JSR writes R7
    add(1, 16'h11C0, 0, 0, 0, 0, 0, 6'd4,  1, 0, 0, 0);  // reads R7
    add(0, 16'h0000, 0, 0, 0, 1, 7, 6'd0,  0, 0, 0, 0);

    model_reset;
    repeat (2) @(posedge clk);
    reset_check;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].ir, tbl[i].ir ^ 16'hA5A5, {tbl[i].ld, 6'h0, tbl[i].ir},
           tbl[i].as, tbl[i].fl, tbl[i].dv, tbl[i].ddr);
      chk($sformatf("tbl%0d_addr", i), 32'(obs_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_stall", i), 32'(obs_stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_av", i), 32'(agex_valid), 32'(tbl[i].e_av));
      if (tbl[i].chk_dr && tbl[i].e_av)
        chk($sformatf("tbl%0d_dr", i), 32'(agex_dr), 32'(tbl[i].e_dr));
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), 16'($urandom), 16'($urandom), 23'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)));
    end

    // Five hazard cycles, then reset while still stalled.
    reset_check;
    step(1, 16'h1400, 16'h0100, {1'b1, 22'h0}, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h1080, 16'h0102, 23'h0, 0, 0, 0, 0);
`ifdef DE_PERF_CNT_EN
    chk("perf_stall_5", 32'(perf_stall_cnt), 32'd5);
    chk("perf_bubble_5", 32'(perf_bubble_cnt), 32'd5);
`endif
    de_valid_in = 1'b1;
    reset_check;
    step(1, 16'h1080, 16'h0102, 23'h0, 0, 0, 0, 0);
    chk("post_rst_stall", 32'(obs_stall), 32'd0);
    chk("post_rst_issue", 32'(agex_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
